// File: rtl/register_file.sv
// RV32I integer register file with x0 hardwired to zero and a pending-write scoreboard for RAW stalls.
// Optional same-cycle write-through (and busy masking) is compiled in with REGFILE_BYPASS_EN.
module register_file #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32,
  localparam int AW       = $clog2(REG_COUNT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_enable,
  input  logic [AW-1:0]   wb_address,
  input  logic [XLEN-1:0] wb_data,
  input  logic [AW-1:0]   rs1_address,
  input  logic [AW-1:0]   rs2_address,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            rs1_used,
  input  logic            rs2_used,
  output logic            hazard_stall
);

  logic [XLEN-1:0]      regs [REG_COUNT];
  logic [REG_COUNT-1:0] pending;
  logic                 wb_write;
  logic                 rs1_busy;
  logic                 rs2_busy;

  assign wb_write = wb_enable && (wb_address != '0);

  // Entry 0 is only ever reset, so it folds to a constant in synthesis.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
      pending <= '0;
    end else begin
      if (wb_write) begin
        regs[wb_address]    <= wb_data;
        pending[wb_address] <= 1'b0;
      end
      // Later assignment wins: the issuing instruction is the newer producer.
      if (issue_valid && (issue_rd != '0)) begin
        pending[issue_rd] <= 1'b1;
      end
    end
  end

  always_comb begin
    rs1_data = (rs1_address == '0) ? '0 : regs[rs1_address];
    rs2_data = (rs2_address == '0) ? '0 : regs[rs2_address];
    rs1_busy = (rs1_address != '0) && pending[rs1_address];
    rs2_busy = (rs2_address != '0) && pending[rs2_address];
`ifdef REGFILE_BYPASS_EN
    // Write-through is suppressed during reset so the outputs show stored state.
    if (!reset && wb_write && (wb_address == rs1_address)) begin
      rs1_data = wb_data;
      rs1_busy = 1'b0;
    end
    if (!reset && wb_write && (wb_address == rs2_address)) begin
      rs2_data = wb_data;
      rs2_busy = 1'b0;
    end
`endif
  end

  assign hazard_stall = (rs1_used && rs1_busy) || (rs2_used && rs2_busy);

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios followed by random traffic
// compared against an array-based reference model.
module tb_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_enable;
  logic [4:0]  wb_address;
  logic [31:0] wb_data;
  logic [4:0]  rs1_address;
  logic [4:0]  rs2_address;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        rs1_used;
  logic        rs2_used;
  logic        hazard_stall;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_regs [32];
  bit          m_pend [32];

  always #5 clk = ~clk;

  register_file dut (
    .clk          (clk),
    .reset        (reset),
    .wb_enable    (wb_enable),
    .wb_address   (wb_address),
    .wb_data      (wb_data),
    .rs1_address  (rs1_address),
    .rs2_address  (rs2_address),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .rs1_used     (rs1_used),
    .rs2_used     (rs2_used),
    .hazard_stall (hazard_stall)
  );

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (!reset && wb_enable && wb_address == a) return wb_data;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (!reset && wb_enable && wb_address == a) return 1'b0;
`endif
    return m_pend[a];
  endfunction

  function automatic logic exp_stall();
    return (rs1_used && exp_busy(rs1_address)) || (rs2_used && exp_busy(rs2_address));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic idle();
    reset       = 1'b0;
    wb_enable   = 1'b0;
    wb_address  = 5'd0;
    wb_data     = 32'h0;
    rs1_address = 5'd0;
    rs2_address = 5'd0;
    issue_valid = 1'b0;
    issue_rd    = 5'd0;
    rs1_used    = 1'b0;
    rs2_used    = 1'b0;
  endtask

  // Check outputs against the model, take the clock edge, then advance the model.
  task automatic cycle();
    #1;
    check("rs1_data", rs1_data, exp_data(rs1_address));
    check("rs2_data", rs2_data, exp_data(rs2_address));
    check("hazard_stall", {31'h0, hazard_stall}, {31'h0, exp_stall()});
    @(posedge clk);
    if (reset) begin
      model_clear();
    end else begin
      if (wb_enable && wb_address != 5'd0) begin
        m_regs[wb_address] = wb_data;
        m_pend[wb_address] = 1'b0;
      end
      if (issue_valid && issue_rd != 5'd0) m_pend[issue_rd] = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] old7;
    idle();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_clear();

    // Reset clears everything.
    for (int i = 0; i < 32; i++) begin
      idle();
      rs1_address = 5'(i);
      rs2_address = 5'(31 - i);
      rs1_used = 1'b1;
      rs2_used = 1'b1;
      #1;
      check("reset_rs1_zero", rs1_data, 32'h0);
      check("reset_stall_zero", {31'h0, hazard_stall}, 32'h0);
      cycle();
    end

    // Basic write and x0 protection.
    idle();
    wb_enable = 1'b1; wb_address = 5'd5; wb_data = 32'hDEAD_BEEF;
    cycle();
    idle();
    rs1_address = 5'd5;
    #1 check("x5_readback", rs1_data, 32'hDEAD_BEEF);
    cycle();
    idle();
    wb_enable = 1'b1; wb_address = 5'd0; wb_data = 32'h1234_5678;
    cycle();
    idle();
    rs2_address = 5'd0;
    #1 check("x0_readback", rs2_data, 32'h0);
    cycle();

    // Same-cycle write and read of x7.
    old7 = m_regs[7];
    idle();
    wb_enable = 1'b1; wb_address = 5'd7; wb_data = 32'hA5A5_A5A5;
    rs1_address = 5'd7;
`ifdef REGFILE_BYPASS_EN
    #1 check("bypass_same_cycle", rs1_data, 32'hA5A5_A5A5);
`else
    #1 check("no_bypass_old_value", rs1_data, old7);
`endif
    cycle();
    idle();
    rs1_address = 5'd7;
    #1 check("x7_next_cycle", rs1_data, 32'hA5A5_A5A5);
    cycle();

    // RAW stall and release on x10.
    idle();
    issue_valid = 1'b1; issue_rd = 5'd10;
    cycle();
    for (int k = 0; k < 2; k++) begin
      idle();
      rs2_address = 5'd10; rs2_used = 1'b1;
      #1 check("raw_stall", {31'h0, hazard_stall}, 32'h1);
      cycle();
    end
    idle();
    rs2_address = 5'd10; rs2_used = 1'b1;
    wb_enable = 1'b1; wb_address = 5'd10; wb_data = 32'h0000_0A0A;
`ifdef REGFILE_BYPASS_EN
    #1 check("raw_release_wb_cycle", {31'h0, hazard_stall}, 32'h0);
`else
    #1 check("raw_hold_wb_cycle", {31'h0, hazard_stall}, 32'h1);
`endif
    cycle();
    idle();
    rs2_address = 5'd10; rs2_used = 1'b1;
    #1 check("raw_released", {31'h0, hazard_stall}, 32'h0);
    check("x10_value", rs2_data, 32'h0000_0A0A);
    cycle();

    // Simultaneous set and clear on x3.
    idle();
    issue_valid = 1'b1; issue_rd = 5'd3;
    cycle();
    idle();
    wb_enable = 1'b1; wb_address = 5'd3; wb_data = 32'h3333_3333;
    issue_valid = 1'b1; issue_rd = 5'd3;
    cycle();
    idle();
    rs1_address = 5'd3; rs1_used = 1'b1;
    #1 check("set_wins_stall", {31'h0, hazard_stall}, 32'h1);
    cycle();
    idle();
    wb_enable = 1'b1; wb_address = 5'd3; wb_data = 32'h3333_4444;
    cycle();

    // Reset in the middle of operation.
    idle();
    wb_enable = 1'b1; wb_address = 5'd4; wb_data = 32'h55;
    cycle();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd4;
    cycle();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd9;
    cycle();
    idle();
    reset = 1'b1;
    wb_enable = 1'b1; wb_address = 5'd4; wb_data = 32'h99;
    issue_valid = 1'b1; issue_rd = 5'd12;
    rs1_address = 5'd4;
    #1 check("reset_cycle_shows_stored", rs1_data, 32'h55);
    cycle();
    idle();
    rs1_address = 5'd4; rs2_address = 5'd9;
    rs1_used = 1'b1; rs2_used = 1'b1;
    #1 check("mid_reset_x4", rs1_data, 32'h0);
    check("mid_reset_stall", {31'h0, hazard_stall}, 32'h0);
    cycle();

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [4:0] rd;
      idle();
      rs1_address = 5'($urandom_range(31));
      rs2_address = 5'($urandom_range(31));
      rs1_used = 1'($urandom_range(1));
      rs2_used = 1'($urandom_range(1));
      if ($urandom_range(1) == 1) begin
        wb_enable  = 1'b1;
        wb_address = 5'($urandom_range(31));
        wb_data    = $urandom;
      end
      rd = 5'($urandom_range(31));
      if (!exp_stall() && !m_pend[rd] && $urandom_range(2) != 0) begin
        issue_valid = 1'b1;
        issue_rd    = rd;
      end
      if ($urandom_range(99) == 0) reset = 1'b1;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

Architectural integer register file for the RV32I core: 32 × 32-bit registers with x0 hardwired to zero. Written once per cycle from the write-back stage result. Read combinationally by the decode stage on two source ports. Also holds a pending-write scoreboard so decode can stall on read-after-write hazards until the producing instruction has written back.

## Interface

Parameters:
- `XLEN`, default 32: register width.
- `REG_COUNT`, default 32: number of architectural registers; address width is log2(REG_COUNT) = 5.

Ports (one clock; reset is synchronous and active-high):
- `clk` input, 1: core clock; all state updates on the rising edge.
- `reset` input, 1: synchronous, active-high.
- `wb_enable` input, 1: write-back commit this cycle.
- `wb_address` input, 5: destination register of the committing instruction.
- `wb_data` input, XLEN: final write-back value, i.e. the ALU result or the load data as already selected by write-back.
- `rs1_address` input, 5: source register 1 read address.
- `rs2_address` input, 5: source register 2 read address.
- `rs1_data` output, XLEN: source 1 operand.
- `rs2_data` output, XLEN: source 2 operand.
- `issue_valid` input, 1: an instruction with a destination register leaves decode this cycle.
- `issue_rd` input, 5: destination of the issuing instruction.
- `rs1_used` input, 1: the decoding instruction reads rs1.
- `rs2_used` input, 1: the decoding instruction reads rs2.
- `hazard_stall` output, 1: decode must hold; a required source has an outstanding write.

## Operation

- **Storage:** `regs[1..31]`, each XLEN bits. x0 is not stored.
  - A read of address 0 returns 0.
  - A write to address 0 is discarded.
- **Write:** at the rising edge, if `wb_enable` is high and `wb_address` is not 0, then `regs[wb_address]` takes `wb_data`.
- **Read:** asynchronous. `rsN_data` equals `regs[rsN_address]`, or 0 for address 0. The write-through behaviour is covered under Configuration.
- **Scoreboard:** `pending[1..31]`, one bit per register. At each rising edge, in this order:
  - If `wb_enable` is high and `wb_address` is not 0, clear `pending[wb_address]`.
  - If `issue_valid` is high and `issue_rd` is not 0, set `pending[issue_rd]`.
  - When issue and write-back target the same register in the same cycle, the set wins, because the issuing instruction is the newer producer.
  - `issue_valid` with `issue_rd` = 0 has no effect.
- **Busy:** `rsN_busy` = `pending[rsN_address]` and (`rsN_address` is not 0).
  - With the bypass compiled in, busy is also masked when `wb_enable` is high and `wb_address` equals `rsN_address` this cycle.
- **Stall:** `hazard_stall` = (`rs1_used` and `rs1_busy`) or (`rs2_used` and `rs2_busy`). It is purely combinational.
- **Issue gating:** upstream must not assert `issue_valid` while `hazard_stall` is high. The block does not gate `issue_valid` internally.
- **Multiple producers:** there is at most one outstanding producer per register. This holds because the pipeline is in-order and the stall is enforced.

## Timing

- **Write-to-read latency:**
  - 0 cycles with the bypass compiled in.
  - Otherwise 1 cycle: the new value is visible the cycle after the write-back edge.
- **Scoreboard latency:** `pending` updates become visible to `hazard_stall` the cycle after the edge.
- **Reset:** on any rising edge with `reset` high:
  - every `regs[i]` becomes 0 and every `pending` bit becomes 0;
  - `wb_enable` and `issue_valid` are ignored that cycle.
  - This applies identically when reset arrives mid-operation.
- **Output values in reset:** while `reset` is high, `rsN_data` reflects the stored values, and `hazard_stall` is 0 from the first cycle after the reset edge onward.
- **Post-reset state:** all reads return 0 and `hazard_stall` is 0.
- **Combinational paths:** `rsN_address` → `rsN_data` and `hazard_stall`; with the bypass compiled in, also `wb_*` → outputs.

## Configuration

- `REGFILE_BYPASS_EN` defined (write-through compiled in):
  - If `wb_enable` is high, `wb_address` is not 0 and `wb_address` equals `rsN_address`, then `rsN_data` = `wb_data` in the same cycle.
  - The matching busy bit is masked, so a consumer of a register being written back this cycle does not stall.
- `REGFILE_BYPASS_EN` undefined:
  - Reads return only stored values.
  - `pending` stays set through the write-back cycle, so the consumer stalls exactly one extra cycle.
  - Address 0 is never bypassed in either build.

## Test plan

- **Reset clears registers:** reset for 1 cycle, then read all 32 addresses → every read returns 0x0000_0000 and `hazard_stall` = 0.
- **Basic write and x0 protection:**
  - Write 0xDEAD_BEEF to x5, then read x5 next cycle → 0xDEAD_BEEF.
  - Write 0x1234_5678 to x0, then read x0 → 0.
- **Same-cycle bypass:** write x7 = 0xA5A5_A5A5 while `rs1_address` = 7 in the same cycle.
  - With the bypass: `rs1_data` = 0xA5A5_A5A5 that cycle.
  - Without it: the old value that cycle, then 0xA5A5_A5A5 the next cycle.
- **RAW stall and release:** issue with rd = 10, then decode reads rs2 = 10 with `rs2_used` = 1 → `hazard_stall` = 1.
  - It stays 1 until the x10 write-back cycle, where it drops to 0 with the bypass.
  - Without the bypass it drops one cycle after the write-back cycle.
- **Simultaneous set and clear:** in the same cycle, write back x3 and issue rd = 3 → `pending[3]` remains 1, and a subsequent read of x3 with `rs1_used` = 1 stalls.
- **Reset mid-operation:** with `pending[4]` and `pending[9]` set and x4 = 0x55, assert reset together with `wb_enable` (x4 = 0x99) → after the edge, x4 = 0 and `hazard_stall` = 0 for rs1 = 4 and rs2 = 9.
